// File: rtl/display7_scan.sv
// Multiplexed seven-segment scanner: prescaled digit scan, frame-aligned
// double-buffered load and optional leading-zero blanking.
module display7_scan #(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] palabra,
  input  logic                  cargar,
  input  logic                  blank_zeros,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_PRE  = CNT_W'(REFRESH_DIV - 2);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE   = {{(N_DIGITS-1){1'b0}}, 1'b1};

  function automatic logic [6:0] seg7_f(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*N_DIGITS-1:0] disp_q, disp_d;
  logic                  pend_q, pend_d;
  logic                  fd_q, fd_d;

  logic                  tick_s;
  logic                  frame_end_s;
  logic                  commit_s;
  logic [N_DIGITS-1:0]   nz_s;
  logic                  blank_s;
  logic [3:0]            nib_s;
  logic [6:0]            seg_hi_s;
  logic [N_DIGITS-1:0]   an_hi_s;

  // Next-state logic for prescaler, digit index, load buffers and frame pulse
  always_comb begin
    tick_s      = (cnt_q == CNT_LAST);
    frame_end_s = tick_s && (idx_q == IDX_LAST);
    commit_s    = frame_end_s && pend_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    if (tick_s) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (commit_s) begin
      disp_d = shadow_q;
    end else begin
      disp_d = disp_q;
    end
    // A load coinciding with a commit keeps pending so the new value lands next frame
    if (cargar) begin
      shadow_d = palabra;
      pend_d   = 1'b1;
    end else if (commit_s) begin
      pend_d   = 1'b0;
    end else begin
      pend_d   = pend_q;
    end
    // Registered pulse is timed one cycle early so it is high on the wrap cycle itself
    fd_d = (cnt_q == CNT_PRE) && (idx_q == IDX_LAST);
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      fd_q     <= fd_d;
    end
  end

  // Digit decode and leading-zero blanking for the digit under scan
  always_comb begin
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      nz_s[j] = |disp_q[j*32'd4 +: 4];
    end
    nib_s = disp_q[{idx_q, 2'b00} +: 4];
    if (blank_zeros && (idx_q != '0) && ((nz_s >> idx_q) == '0)) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end
    if (blank_s) begin
      seg_hi_s = 7'h00;
      an_hi_s  = '0;
    end else begin
      seg_hi_s = seg7_f(nib_s);
      an_hi_s  = AN_ONE << idx_q;
    end
  end

  // Output polarity
  always_comb begin
    if (SEG_ACTIVE_LOW) begin
      seg = ~seg_hi_s;
      an  = ~an_hi_s;
    end else begin
      seg = seg_hi_s;
      an  = an_hi_s;
    end
  end

  assign frame_done = fd_q;

endmodule

// File: doc/display7_scan.md
DISPLAY7_SCAN -- requirements
Module: display7_scan

Interface
Parameters:
REQ-001 SHALL have parameter N_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clocks per digit slot, minimum 2.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1: if 1, seg and an are active-low; if 0, both are active-high.

Ports:
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port palabra, input, 4*N_DIGITS bits: hex nibbles; nibble k (bits 4k+3..4k) is digit k, and digit 0 is least significant.
REQ-007 SHALL have port cargar, input, 1 bit: load strobe; samples palabra on that clock edge.
REQ-008 SHALL have port blank_zeros, input, 1 bit: enables leading-zero blanking.
REQ-009 SHALL have port seg, output, 7 bits: segments, with seg[0]=a through seg[6]=g.
REQ-010 SHALL have port an, output, N_DIGITS bits: digit enables; an[k] drives digit k.
REQ-011 SHALL have port frame_done, output, 1 bit: one-clock pulse at the end of each full scan.

Function
REQ-012 SHALL contain a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; a tick occurs on the cycle the count equals REFRESH_DIV-1.
REQ-013 SHALL advance the digit index (0..N_DIGITS-1) on each tick, wrapping N_DIGITS-1 to 0.
REQ-014 SHALL treat a tick that wraps the index to 0 as end-of-frame; frame_done SHALL be 1 for exactly that cycle.
REQ-015 SHALL, on cargar=1, copy palabra into a shadow register and set the pending flag.
REQ-016 SHALL, at end-of-frame with pending=1, copy shadow into the display register and clear pending; the display register SHALL NOT change at any other time (no tearing).
REQ-017 SHALL, when cargar and commit coincide, commit the old shadow value, load the new palabra into shadow, and leave pending=1; the new value appears one frame later.
REQ-018 SHALL, when cargar is held high for several cycles, have the last sampled value win.
REQ-019 SHALL decode the nibble at the current index with active-high gfedcba patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 SHALL, when SEG_ACTIVE_LOW=1, bitwise-invert seg and an relative to their active-high values.
REQ-021 SHALL set the active-high an to one-hot at the current index.
REQ-022 SHALL, when blank_zeros=1, blank digit k (seg all off, an[k] off) if display nibbles N_DIGITS-1 down to k are all zero and k>0; digit 0 SHALL never be blanked.
REQ-023 SHALL apply blank_zeros combinationally, without waiting for a frame boundary.
REQ-024 SHALL generate seg and an combinationally from registered state (index, display register, blank_zeros) only; they change in the same cycle as the index register.
REQ-025 SHALL size all counters to ceil(log2) of their range; the prescaler width SHALL hold REFRESH_DIV-1 without overflow.

Reset
REQ-026 SHALL, on rst_n=0 and without waiting for a clock, clear the prescaler, index, shadow, display register, pending and frame_done to 0.
REQ-027 SHALL, during reset, drive an with digit 0 enabled and seg showing "0" (defaults N_DIGITS=4, SEG_ACTIVE_LOW=1: an=1110, seg=7'h40).
REQ-028 SHALL, after reset is asserted mid-frame or mid-load, discard any pending load; scanning restarts at digit 0 with a full REFRESH_DIV slot after rst_n rises.

Verification
Bench settings: N_DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=1.
REQ-029 SHALL verify reset: rst_n=0 -> an=1110, seg=7'h40, frame_done=0, with no clock edge required.
REQ-030 SHALL verify the scan: with rst_n released, an sequence is 1110, 1101, 1011, 0111, 1110, each held 4 clocks, and frame_done pulses once per 16 clocks when 0111 -> 1110.
REQ-031 SHALL verify a deferred load: palabra=16'h1234 with cargar pulsed mid-frame -> display unchanged until the next frame_done; afterwards digit 0 seg=7'h19 ("4") and digit 3 seg=7'h79 ("1").
REQ-032 SHALL verify blanking: blank_zeros=1 with committed 16'h0050 -> digits 3 and 2 have an off and seg=7'h7F, digit 1 shows "5" (7'h12), digit 0 shows "0" (7'h40); with 16'h0000 only digit 0 is lit.
REQ-033 SHALL verify the collision: cargar with 16'hABCD on the frame_done cycle while shadow holds 16'h1111 -> the frame shows 1111 and the next frame shows ABCD.
REQ-034 SHALL verify reset mid-operation: rst_n pulsed low for 1 clock at index 2 with pending=1 -> immediate return to the REQ-027 values and the pending load discarded.
